ascon_linear_layer: RTL and testbench

- Linear diffusion stage (p_L) of the ASCON permutation. Sits directly downstream of the 64-column bit-sliced substitution layer.
- Receives the 320-bit post-S-box state over a valid/ready handshake and applies the per-lane XOR-of-rotations.
- Returns the diffused state over a valid/ready handshake to the round controller.
- Build-time option: full-parallel (1 cycle) or lane-serial (5 cycles, one shared rotate/XOR datapath) for area-constrained SoC builds.

---
 rtl/ascon_linear_layer.sv | 139 +++++++++++++
 tb/tb_ascon_linear_layer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_linear_layer.sv
// ascon_linear_layer
// Linear diffusion stage (p_L) of the ASCON permutation. Each 64-bit lane is
// XORed with two right-rotations of itself. SERIAL=0 diffuses all five lanes
// in one cycle. SERIAL=1 diffuses one lane per cycle through a shared
// rotate/XOR datapath, x0 first and x4 last.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_state is valid
//   in_ready   block can accept in_state this cycle
//   in_state   post-S-box state {x0,x1,x2,x3,x4}, x0 in [319:256]
//   out_valid  out_state holds a diffused state
//   out_ready  consumer accepts out_state
//   out_state  diffused state, same packing as in_state
//   busy       high while a state is in flight or waiting to be taken
module ascon_linear_layer #(
   parameter bit SERIAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [319:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [2:0]   lane_q, lane_d;
   logic [319:0] buf_q, buf_d;
   logic [319:0] out_state_q, out_state_d;
   logic [319:0] diff_all;
   logic [8:0]   lane_base;
   logic [63:0]  lane_in;
   logic [63:0]  lane_res;
   logic         accept;

   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [6:0] r);
      logic [127:0] t;
      // Low half of {x,x} shifted right is the 64-bit right rotation.
      t = {x, x} >> r;
      return t[63:0];
   endfunction

   // Rotation pair {a,b} for lane k (k=0 is x0).
   function automatic logic [13:0] rot_pair(input logic [2:0] k);
      logic [13:0] rp;
      case (k)
         3'd0:    rp = {7'd19, 7'd28};
         3'd1:    rp = {7'd61, 7'd39};
         3'd2:    rp = {7'd1,  7'd6};
         3'd3:    rp = {7'd10, 7'd17};
         default: rp = {7'd7,  7'd41};
      endcase
      return rp;
   endfunction

   function automatic logic [63:0] diffuse(input logic [63:0] x, input logic [13:0] rp);
      return x ^ ror64(x, rp[13:7]) ^ ror64(x, rp[6:0]);
   endfunction

   // Full-parallel datapath: all five lanes from the work buffer.
   for (genvar gi = 0; gi < 5; gi++) begin : g_lane
      assign diff_all[(4-gi)*64 +: 64] = diffuse(buf_q[(4-gi)*64 +: 64], rot_pair(3'(gi)));
   end

   // Shared lane datapath: lane k lives at bit offset (4-k)*64.
   assign lane_base = {3'd4 - lane_q, 6'd0};
   assign lane_in   = buf_q[lane_base +: 64];
   assign lane_res  = diffuse(lane_in, rot_pair(lane_q));

   // in_ready follows out_ready in DONE so a new state can enter on the
   // same edge the previous result leaves.
   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = out_state_q;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      buf_d       = buf_q;
      out_state_d = out_state_q;
      case (state_q)
         IDLE: ;
         BUSY: begin
            if (SERIAL) begin
               // Unwritten lanes keep their previous contents.
               out_state_d[lane_base +: 64] = lane_res;
               if (lane_q == 3'd4) begin
                  state_d = DONE;
               end else begin
                  lane_d = lane_q + 3'd1;
               end
            end else begin
               out_state_d = diff_all;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A capture overrides the DONE->IDLE exit (zero-bubble hand-over).
      if (accept) begin
         buf_d   = in_state;
         lane_d  = 3'd0;
         state_d = BUSY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lane_q      <= 3'd0;
         buf_q       <= '0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         buf_q       <= buf_d;
         out_state_q <= out_state_d;
      end
   end

endmodule

// File: tb/tb_ascon_linear_layer.sv
// tb_ascon_linear_layer
// Bench for ascon_linear_layer. Instance 0 is SERIAL=0, instance 1 is
// SERIAL=1. Drivers push expected results into a per-instance queue when an
// input handshake is seen; a monitor pops and compares on each output
// handshake.
`timescale 1ns/1ps
module tb_ascon_linear_layer;

   logic         clk;
   logic         rst_n;
   logic [1:0]   in_valid;
   logic [1:0]   in_ready;
   logic [1:0]   out_valid;
   logic [1:0]   out_ready;
   logic [1:0]   busy;
   logic [1:0]   rnd_ready;
   logic [319:0] in_state0, in_state1;
   logic [319:0] out_state0, out_state1;
   logic [319:0] exp0[$];
   logic [319:0] exp1[$];
   int           pass_cnt = 0;
   int           total_cnt = 0;
   int           txn_cnt[2] = '{0, 0};

   localparam logic [319:0] V_BIT = {64'h1, 64'h0, 64'h1, 64'h0, 64'h0};
   localparam logic [319:0] E_BIT = {64'h0000201000000001, 64'h0,
                                     64'h8400000000000001, 64'h0, 64'h0};
   localparam logic [319:0] V_ONE = {256'h0, 64'hFFFFFFFFFFFFFFFF};

   ascon_linear_layer #(.SERIAL(1'b0)) u_par (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state0),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state0),
      .busy(busy[0])
   );

   ascon_linear_layer #(.SERIAL(1'b1)) u_ser (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state1),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state1),
      .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-level reference: ror(x,r)[i] = x[(i+r) mod 64].
   function automatic logic [319:0] pl_model(input logic [319:0] s);
      int           ra[5] = '{19, 61, 1, 10, 7};
      int           rb[5] = '{28, 39, 6, 17, 41};
      logic [319:0] r;
      logic [63:0]  x, y;
      r = '0;
      for (int l = 0; l < 5; l++) begin
         x = s[(4-l)*64 +: 64];
         for (int i = 0; i < 64; i++) begin
            y[i] = x[i] ^ x[(i + ra[l]) % 64] ^ x[(i + rb[l]) % 64];
         end
         r[(4-l)*64 +: 64] = y;
      end
      return r;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [319:0] get_out(input int idx);
      return (idx == 0) ? out_state0 : out_state1;
   endfunction

   function automatic int exp_size(input int idx);
      return (idx == 0) ? exp0.size() : exp1.size();
   endfunction

   task automatic check(input string name, input logic [319:0] got, input logic [319:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, got, want);
   endtask

   task automatic set_state(input int idx, input logic [319:0] d);
      if (idx == 0) in_state0 = d;
      else          in_state1 = d;
   endtask

   // Presents d, waits (bounded) for the handshake, records the expectation.
   // Returns just after the accept edge with in_valid still high.
   task automatic send(input int idx, input logic [319:0] d, input logic [319:0] e);
      int n = 0;
      set_state(idx, d);
      in_valid[idx] = 1'b1;
      @(negedge clk);
      while (!in_ready[idx] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[idx]) begin
         check($sformatf("accept_timeout%0d", idx), 320'(in_ready[idx]), 320'(1));
      end else if (idx == 0) begin
         exp0.push_back(e);
      end else begin
         exp1.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int idx, output int n);
      n = 0;
      while (!out_valid[idx] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic drain(input int idx);
      int n = 0;
      while (exp_size(idx) > 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check($sformatf("drain%0d", idx), 320'(exp_size(idx)), 320'(0));
   endtask

   // Scoreboard monitor: one compare per output handshake.
   initial begin
      logic [319:0] e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst_n === 1'b1 && out_valid[k] && out_ready[k]) begin
               if (exp_size(k) == 0) begin
                  check($sformatf("unexpected_out%0d", k), 320'(1), 320'(0));
               end else begin
                  e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                  check($sformatf("out_state%0d", k), get_out(k), e);
                  txn_cnt[k]++;
                  $display("dut%0d txn %0d x0=%h x4=%h", k, txn_cnt[k],
                           e[319:256], e[63:0]);
               end
            end
         end
      end
   end

   // Random consumer back-pressure when enabled.
   initial begin
      rnd_ready = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rnd_ready[k]) out_ready[k] = ($urandom_range(0, 2) != 0);
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      logic [319:0] d, e;
      in_valid  = 2'b00;
      out_ready = 2'b00;
      in_state0 = '0;
      in_state1 = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_out_valid%0d", k), 320'(out_valid[k]), 320'(0));
         check($sformatf("rst_in_ready%0d", k), 320'(in_ready[k]), 320'(1));
         check($sformatf("rst_busy%0d", k), 320'(busy[k]), 320'(0));
         check($sformatf("rst_out_state%0d", k), get_out(k), 320'(0));
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 2; k++) begin
         // Single-bit lanes with latency measurement.
         out_ready[k] = 1'b1;
         send(k, V_BIT, E_BIT);
         in_valid[k] = 1'b0;
         wait_valid(k, lat);
         check($sformatf("latency%0d", k), 320'(lat), 320'((k == 0) ? 1 : 5));
         @(posedge clk);
         #1;
         // Fixed points.
         send(k, 320'(0), 320'(0));
         send(k, V_ONE, V_ONE);
         in_valid[k] = 1'b0;
         drain(k);

         // Back-pressure: result held, input blocked, exactly one transfer.
         out_ready[k] = 1'b0;
         d = rand320();
         e = pl_model(d);
         send(k, d, e);
         in_valid[k] = 1'b0;
         wait_valid(k, lat);
         check($sformatf("bp_valid%0d", k), 320'(out_valid[k]), 320'(1));
         for (int c = 0; c < 10; c++) begin
            in_valid[k] = c[0];
            set_state(k, rand320());
            @(negedge clk);
            check($sformatf("bp_stable%0d", k), get_out(k), e);
            check($sformatf("bp_in_ready%0d", k), 320'(in_ready[k]), 320'(0));
            @(posedge clk);
            #1;
         end
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("bp_released%0d", k), 320'(out_valid[k]), 320'(0));
         @(posedge clk);
         #1;
         check($sformatf("bp_one_transfer%0d", k), 320'(exp_size(k)), 320'(0));
         check($sformatf("bp_idle_busy%0d", k), 320'(busy[k]), 320'(0));

         // Back-to-back with in_valid held high.
         for (int i = 0; i < 4; i++) begin
            d = rand320();
            send(k, d, pl_model(d));
         end
         in_valid[k] = 1'b0;
         drain(k);
      end

      // Asynchronous reset in the middle of a serial operation.
      d = rand320();
      send(1, d, pl_model(d));
      in_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("mid_busy", 320'(busy[1]), 320'(1));
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 320'(out_valid[1]), 320'(0));
      check("arst_out_state", out_state1, 320'(0));
      check("arst_in_ready", 320'(in_ready[1]), 320'(1));
      check("arst_busy", 320'(busy[1]), 320'(0));
      exp1.delete();
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1, V_BIT, E_BIT);
      in_valid[1] = 1'b0;
      drain(1);

      // Random traffic with random ready toggling.
      for (int k = 0; k < 2; k++) begin
         rnd_ready[k] = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            d = rand320();
            send(k, d, pl_model(d));
            if ($urandom_range(0, 3) == 0) begin
               in_valid[k] = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         in_valid[k] = 1'b0;
         drain(k);
         rnd_ready[k] = 1'b0;
         #2;
         out_ready[k] = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("rnd_no_extra%0d", k), 320'(out_valid[k]), 320'(0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
